// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N-input round-robin/fixed multiplexer.
//   clog2()     - ceiling log2, used to size channel indices (returns >= 1)
//   MODE_FIXED  - rr_en value selecting fixed-channel mode
//   MODE_RR     - rr_en value selecting round-robin mode
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Minimum of 1 so a 2-channel mux still gets a 1-bit index.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational rotating-priority arbiter.
//   req  [N-1:0]  request vector
//   ptr  [PW-1:0] highest-priority index for this cycle (must be < N)
//   gnt  [N-1:0]  one-hot grant, zero when no request
//   idx  [PW-1:0] encoded index of the granted request (0 when none)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int  scan;
  logic found;

  // Scan ptr, ptr+1, ... wrapping modulo N; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    scan  = 0;
    for (int k = 0; k < N; k++) begin
      scan = (int'(ptr) + k) % N;
      if (!found && req[scan]) begin
        found     = 1'b1;
        gnt[scan] = 1'b1;
        idx       = PW'(scan);
      end
    end
  end

endmodule

// File: rtl/mux_nin_1out_rr.sv
// mux_nin_1out_rr: N-input, W-bit valid/ready multiplexer with a registered
// output stage and runtime choice of fixed-select or round-robin arbitration.
//   clk, rst   clock (rising edge) and synchronous active-high reset
//   in_data    N_IN*W  channel i at [i*W +: W]
//   in_valid   N_IN    per-channel valid
//   in_ready   N_IN    per-channel ready, one-hot or zero
//   rr_en      1       MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel        SEL_W   channel chosen in fixed mode; >= N_IN grants nothing
//   out_data   W       held word
//   out_ch     SEL_W   channel that supplied out_data
//   out_valid  1       a word is held
//   out_ready  1       consumer accepts the held word
module mux_nin_1out_rr
  import mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [N_IN-1:0]   in_valid,
  output logic [N_IN-1:0]   in_ready,
  input  logic              rr_en,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N_IN-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic [N_IN-1:0]  fix_gnt;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             in_xfer;

  rr_arbiter #(
    .N  (N_IN),
    .PW (SEL_W)
  ) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Comparing against every channel index means an out-of-range sel
  // simply matches nothing.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      fix_gnt[i] = in_valid[i] && (int'(sel) == i);
    end
  end

  assign grant     = (rr_en == MODE_RR) ? rr_gnt : fix_gnt;
  assign grant_idx = (rr_en == MODE_RR) ? rr_idx : sel;
  assign load_en   = !out_valid || out_ready;
  assign in_ready  = (!rst && load_en) ? grant : '0;
  // A grant implies the channel is valid, so any ready bit is a transfer.
  assign in_xfer   = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (in_xfer) begin
        out_data  <= in_data[grant_idx*W +: W];
        out_ch    <= grant_idx;
        out_valid <= 1'b1;
        if (rr_en == MODE_RR) begin
          ptr <= SEL_W'((int'(grant_idx) + 1) % N_IN);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
